nasti_channel_buf: RTL and testbench

NASTI_CHANNEL_BUF -- requirements
Module: nasti_channel_buf

---
 rtl/nasti_buf_pkg.sv | 34 +++
 rtl/nasti_ar.sv | 25 ++
 rtl/nasti_aw.sv | 26 ++
 rtl/nasti_b.sv | 14 +
 rtl/nasti_r.sv | 17 +
 rtl/nasti_w.sv | 15 +
 rtl/nasti_buf_fifo.sv | 70 +++++++
 rtl/nasti_channel_buf.sv | 144 ++++++++++++++
 tb/tb_nasti_channel_buf.sv | 388 ++++++++++++++++++++++++++++++++++++++
 9 files changed

// File: rtl/nasti_buf_pkg.sv
// Shared constants for the NASTI channel buffer: channel indices and the
// packed payload width of each channel (every field except valid/ready).
package nasti_buf_pkg;

  localparam int CH_AW = 0;
  localparam int CH_W  = 1;
  localparam int CH_B  = 2;
  localparam int CH_AR = 3;
  localparam int CH_R  = 4;

  // len + size + burst + lock + cache + prot + qos + region
  localparam int AX_FIXED_W = 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4;

  function automatic int aw_width(int id_w, int addr_w, int user_w);
    return id_w + addr_w + user_w + AX_FIXED_W;
  endfunction

  function automatic int ar_width(int id_w, int addr_w, int user_w);
    return id_w + addr_w + user_w + AX_FIXED_W;
  endfunction

  function automatic int w_width(int data_w, int user_w);
    return data_w + data_w / 8 + 1 + user_w;
  endfunction

  function automatic int b_width(int id_w, int user_w);
    return id_w + 2 + user_w;
  endfunction

  function automatic int r_width(int id_w, int data_w, int user_w);
    return id_w + data_w + 2 + 1 + user_w;
  endfunction

endpackage

// File: rtl/nasti_ar.sv
// NASTI read-address channel.
interface nasti_ar #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]   id;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            len;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic                  lock;
  logic [3:0]            cache;
  logic [2:0]            prot;
  logic [3:0]            qos;
  logic [3:0]            region;
  logic [USER_WIDTH-1:0] user;
  logic                  valid;
  logic                  ready;

  modport master (output id, addr, len, size, burst, lock, cache, prot, qos,
                  region, user, valid, input ready);
  modport slave  (input id, addr, len, size, burst, lock, cache, prot, qos,
                  region, user, valid, output ready);
endinterface

// File: rtl/nasti_aw.sv
// NASTI write-address channel. Handshake: a beat transfers on a rising edge
// where valid && ready; once valid is high the payload is held until then.
interface nasti_aw #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]   id;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            len;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic                  lock;
  logic [3:0]            cache;
  logic [2:0]            prot;
  logic [3:0]            qos;
  logic [3:0]            region;
  logic [USER_WIDTH-1:0] user;
  logic                  valid;
  logic                  ready;

  modport master (output id, addr, len, size, burst, lock, cache, prot, qos,
                  region, user, valid, input ready);
  modport slave  (input id, addr, len, size, burst, lock, cache, prot, qos,
                  region, user, valid, output ready);
endinterface

// File: rtl/nasti_b.sv
// NASTI write-response channel; the slave side drives payload and valid.
interface nasti_b #(
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]   id;
  logic [1:0]            resp;
  logic [USER_WIDTH-1:0] user;
  logic                  valid;
  logic                  ready;

  modport master (input id, resp, user, valid, output ready);
  modport slave  (output id, resp, user, valid, input ready);
endinterface

// File: rtl/nasti_r.sv
// NASTI read-data channel; the slave side drives payload and valid.
interface nasti_r #(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [1:0]            resp;
  logic                  last;
  logic [USER_WIDTH-1:0] user;
  logic                  valid;
  logic                  ready;

  modport master (input id, data, resp, last, user, valid, output ready);
  modport slave  (output id, data, resp, last, user, valid, input ready);
endinterface

// File: rtl/nasti_w.sv
// NASTI write-data channel (AXI4, no write id).
interface nasti_w #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;
  logic                    last;
  logic [USER_WIDTH-1:0]   user;
  logic                    valid;
  logic                    ready;

  modport master (output data, strb, last, user, valid, input ready);
  modport slave  (input data, strb, last, user, valid, output ready);
endinterface

// File: rtl/nasti_buf_fifo.sv
// Single-clock FIFO for one packed channel payload. DEPTH=0 is a wire;
// otherwise valid/ready come straight from the count register.
module nasti_buf_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  if (DEPTH == 0) begin : g_pass
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign out_data_o  = in_data_i;

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end else begin : g_fifo
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Ready ignores a same-cycle pop so no input reaches any ready/valid.
    assign in_ready_o  = (count_q != FULL_CNT);
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/nasti_channel_buf.sv
// Five independent NASTI channel FIFOs. Defining NASTI_CHANNEL_BUF_CHK_EN adds
// the err port and a sticky checker for source-side valid/payload stability.
module nasti_channel_buf
  import nasti_buf_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int ADDR_DEPTH = 2,
  parameter int DATA_DEPTH = 2
) (
  input logic     clk,
  input logic     rst,
  nasti_aw.slave  s_aw,
  nasti_w.slave   s_w,
  nasti_b.slave   s_b,
  nasti_ar.slave  s_ar,
  nasti_r.slave   s_r,
  nasti_aw.master m_aw,
  nasti_w.master  m_w,
  nasti_b.master  m_b,
  nasti_ar.master m_ar,
  nasti_r.master  m_r
`ifdef NASTI_CHANNEL_BUF_CHK_EN
  ,
  output logic [4:0] err
`endif
);

  localparam int AW_W = aw_width(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
  localparam int W_W  = w_width(DATA_WIDTH, USER_WIDTH);
  localparam int B_W  = b_width(ID_WIDTH, USER_WIDTH);
  localparam int AR_W = ar_width(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
  localparam int R_W  = r_width(ID_WIDTH, DATA_WIDTH, USER_WIDTH);

  logic [AW_W-1:0] aw_in, aw_out;
  logic [W_W-1:0]  w_in,  w_out;
  logic [B_W-1:0]  b_in,  b_out;
  logic [AR_W-1:0] ar_in, ar_out;
  logic [R_W-1:0]  r_in,  r_out;

  assign aw_in = {s_aw.id, s_aw.addr, s_aw.len, s_aw.size, s_aw.burst, s_aw.lock,
                  s_aw.cache, s_aw.prot, s_aw.qos, s_aw.region, s_aw.user};
  assign {m_aw.id, m_aw.addr, m_aw.len, m_aw.size, m_aw.burst, m_aw.lock,
          m_aw.cache, m_aw.prot, m_aw.qos, m_aw.region, m_aw.user} = aw_out;

  assign w_in = {s_w.data, s_w.strb, s_w.last, s_w.user};
  assign {m_w.data, m_w.strb, m_w.last, m_w.user} = w_out;

  // Response channels flow downstream to upstream.
  assign b_in = {m_b.id, m_b.resp, m_b.user};
  assign {s_b.id, s_b.resp, s_b.user} = b_out;

  assign ar_in = {s_ar.id, s_ar.addr, s_ar.len, s_ar.size, s_ar.burst, s_ar.lock,
                  s_ar.cache, s_ar.prot, s_ar.qos, s_ar.region, s_ar.user};
  assign {m_ar.id, m_ar.addr, m_ar.len, m_ar.size, m_ar.burst, m_ar.lock,
          m_ar.cache, m_ar.prot, m_ar.qos, m_ar.region, m_ar.user} = ar_out;

  assign r_in = {m_r.id, m_r.data, m_r.resp, m_r.last, m_r.user};
  assign {s_r.id, s_r.data, s_r.resp, s_r.last, s_r.user} = r_out;

  nasti_buf_fifo #(.WIDTH(AW_W), .DEPTH(ADDR_DEPTH)) u_aw_fifo (
    .clk(clk), .rst(rst),
    .in_valid_i(s_aw.valid), .in_ready_o(s_aw.ready), .in_data_i(aw_in),
    .out_valid_o(m_aw.valid), .out_ready_i(m_aw.ready), .out_data_o(aw_out)
  );

  nasti_buf_fifo #(.WIDTH(W_W), .DEPTH(DATA_DEPTH)) u_w_fifo (
    .clk(clk), .rst(rst),
    .in_valid_i(s_w.valid), .in_ready_o(s_w.ready), .in_data_i(w_in),
    .out_valid_o(m_w.valid), .out_ready_i(m_w.ready), .out_data_o(w_out)
  );

  nasti_buf_fifo #(.WIDTH(B_W), .DEPTH(ADDR_DEPTH)) u_b_fifo (
    .clk(clk), .rst(rst),
    .in_valid_i(m_b.valid), .in_ready_o(m_b.ready), .in_data_i(b_in),
    .out_valid_o(s_b.valid), .out_ready_i(s_b.ready), .out_data_o(b_out)
  );

  nasti_buf_fifo #(.WIDTH(AR_W), .DEPTH(ADDR_DEPTH)) u_ar_fifo (
    .clk(clk), .rst(rst),
    .in_valid_i(s_ar.valid), .in_ready_o(s_ar.ready), .in_data_i(ar_in),
    .out_valid_o(m_ar.valid), .out_ready_i(m_ar.ready), .out_data_o(ar_out)
  );

  nasti_buf_fifo #(.WIDTH(R_W), .DEPTH(DATA_DEPTH)) u_r_fifo (
    .clk(clk), .rst(rst),
    .in_valid_i(m_r.valid), .in_ready_o(m_r.ready), .in_data_i(r_in),
    .out_valid_o(s_r.valid), .out_ready_i(s_r.ready), .out_data_o(r_out)
  );

`ifdef NASTI_CHANNEL_BUF_CHK_EN
  logic [4:0]      src_valid, src_ready, payload_chg;
  logic [4:0]      valid_q, ready_q, err_q;
  logic [AW_W-1:0] aw_hold_q;
  logic [W_W-1:0]  w_hold_q;
  logic [B_W-1:0]  b_hold_q;
  logic [AR_W-1:0] ar_hold_q;
  logic [R_W-1:0]  r_hold_q;

  assign src_valid[CH_AW] = s_aw.valid;
  assign src_valid[CH_W]  = s_w.valid;
  assign src_valid[CH_B]  = m_b.valid;
  assign src_valid[CH_AR] = s_ar.valid;
  assign src_valid[CH_R]  = m_r.valid;

  assign src_ready[CH_AW] = s_aw.ready;
  assign src_ready[CH_W]  = s_w.ready;
  assign src_ready[CH_B]  = m_b.ready;
  assign src_ready[CH_AR] = s_ar.ready;
  assign src_ready[CH_R]  = m_r.ready;

  assign payload_chg[CH_AW] = (aw_in != aw_hold_q);
  assign payload_chg[CH_W]  = (w_in  != w_hold_q);
  assign payload_chg[CH_B]  = (b_in  != b_hold_q);
  assign payload_chg[CH_AR] = (ar_in != ar_hold_q);
  assign payload_chg[CH_R]  = (r_in  != r_hold_q);

  // A stalled beat (valid && !ready last cycle) must keep valid and payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= src_valid;
      ready_q <= src_ready;
      err_q   <= err_q | (valid_q & ~ready_q & (~src_valid | payload_chg));
    end
  end

  always_ff @(posedge clk) begin
    aw_hold_q <= aw_in;
    w_hold_q  <= w_in;
    b_hold_q  <= b_in;
    ar_hold_q <= ar_in;
    r_hold_q  <= r_in;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_nasti_channel_buf.sv
// Bench for nasti_channel_buf: instance A (ADDR_DEPTH=3, DATA_DEPTH=2) and
// instance B (ADDR_DEPTH=2, DATA_DEPTH=0); checker test when NASTI_CHANNEL_BUF_CHK_EN.
module tb_nasti_channel_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  nasti_aw a_s_aw(), a_m_aw(), b_s_aw(), b_m_aw();
  nasti_w  a_s_w(),  a_m_w(),  b_s_w(),  b_m_w();
  nasti_b  a_s_b(),  a_m_b(),  b_s_b(),  b_m_b();
  nasti_ar a_s_ar(), a_m_ar(), b_s_ar(), b_m_ar();
  nasti_r  a_s_r(),  a_m_r(),  b_s_r(),  b_m_r();

`ifdef NASTI_CHANNEL_BUF_CHK_EN
  logic [4:0] a_err, b_err;
`endif

  nasti_channel_buf #(.ADDR_DEPTH(3), .DATA_DEPTH(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .s_aw(a_s_aw), .s_w(a_s_w), .s_b(a_s_b), .s_ar(a_s_ar), .s_r(a_s_r),
    .m_aw(a_m_aw), .m_w(a_m_w), .m_b(a_m_b), .m_ar(a_m_ar), .m_r(a_m_r)
`ifdef NASTI_CHANNEL_BUF_CHK_EN
    , .err(a_err)
`endif
  );

  nasti_channel_buf #(.ADDR_DEPTH(2), .DATA_DEPTH(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .s_aw(b_s_aw), .s_w(b_s_w), .s_b(b_s_b), .s_ar(b_s_ar), .s_r(b_s_r),
    .m_aw(b_m_aw), .m_w(b_m_w), .m_b(b_m_b), .m_ar(b_m_ar), .m_r(b_m_r)
`ifdef NASTI_CHANNEL_BUF_CHK_EN
    , .err(b_err)
`endif
  );

  initial begin
    #400000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_all();
    {a_s_aw.id, a_s_aw.addr, a_s_aw.len, a_s_aw.size, a_s_aw.burst, a_s_aw.lock, a_s_aw.cache,
     a_s_aw.prot, a_s_aw.qos, a_s_aw.region, a_s_aw.user, a_s_aw.valid} = '0;
    {b_s_aw.id, b_s_aw.addr, b_s_aw.len, b_s_aw.size, b_s_aw.burst, b_s_aw.lock, b_s_aw.cache,
     b_s_aw.prot, b_s_aw.qos, b_s_aw.region, b_s_aw.user, b_s_aw.valid} = '0;
    {a_s_ar.id, a_s_ar.addr, a_s_ar.len, a_s_ar.size, a_s_ar.burst, a_s_ar.lock, a_s_ar.cache,
     a_s_ar.prot, a_s_ar.qos, a_s_ar.region, a_s_ar.user, a_s_ar.valid} = '0;
    {b_s_ar.id, b_s_ar.addr, b_s_ar.len, b_s_ar.size, b_s_ar.burst, b_s_ar.lock, b_s_ar.cache,
     b_s_ar.prot, b_s_ar.qos, b_s_ar.region, b_s_ar.user, b_s_ar.valid} = '0;
    {a_s_w.data, a_s_w.strb, a_s_w.last, a_s_w.user, a_s_w.valid} = '0;
    {b_s_w.data, b_s_w.strb, b_s_w.last, b_s_w.user, b_s_w.valid} = '0;
    {a_m_b.id, a_m_b.resp, a_m_b.user, a_m_b.valid} = '0;
    {b_m_b.id, b_m_b.resp, b_m_b.user, b_m_b.valid} = '0;
    {a_m_r.id, a_m_r.data, a_m_r.resp, a_m_r.last, a_m_r.user, a_m_r.valid} = '0;
    {b_m_r.id, b_m_r.data, b_m_r.resp, b_m_r.last, b_m_r.user, b_m_r.valid} = '0;
    {a_m_aw.ready, a_m_w.ready, a_s_b.ready, a_m_ar.ready, a_s_r.ready} = 5'b11111;
    {b_m_aw.ready, b_m_w.ready, b_s_b.ready, b_m_ar.ready, b_s_r.ready} = 5'b11111;
  endtask

  task automatic test_reset();
    logic [4:0] vld, rdy;
    rst = 1'b1;
    tick();
    @(negedge clk);
    vld = {a_m_aw.valid, a_m_w.valid, a_s_b.valid, a_m_ar.valid, a_s_r.valid};
    rdy = {a_s_aw.ready, a_s_w.ready, a_m_b.ready, a_s_ar.ready, a_m_r.ready};
    total++;
    if (vld !== 5'b00000) begin bad++; $display("FAIL reset_a_valid got=%b want=00000", vld); end
    total++;
    if (rdy !== 5'b11111) begin bad++; $display("FAIL reset_a_ready got=%b want=11111", rdy); end
    vld = {b_m_aw.valid, 1'b0, b_s_b.valid, b_m_ar.valid, 1'b0};
    rdy = {b_s_aw.ready, 1'b1, b_m_b.ready, b_s_ar.ready, 1'b1};
    total++;
    if (vld !== 5'b00000) begin bad++; $display("FAIL reset_b_valid got=%b want=00000", vld); end
    total++;
    if (rdy !== 5'b11111) begin bad++; $display("FAIL reset_b_ready got=%b want=11111", rdy); end
`ifdef NASTI_CHANNEL_BUF_CHK_EN
    total++;
    if (a_err !== 5'b0 || b_err !== 5'b0) begin
      bad++; $display("FAIL reset_err got a=%b b=%b want=00000", a_err, b_err);
    end
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_w_stream();
    exp_q.delete();
    a_m_w.ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a_s_w.valid = (k < 8);
      a_s_w.data  = 8'(k);
      a_s_w.strb  = 1'b1;
      a_s_w.last  = (k == 7);
      @(negedge clk);
      if (k == 0 || k == 9) begin
        total++;
        if (a_m_w.valid !== 1'b0) begin bad++; $display("FAIL w_idle k=%0d valid got=%b want=0", k, a_m_w.valid); end
      end else begin
        total++;
        if (a_m_w.valid !== 1'b1 || exp_q.size() == 0) begin
          bad++; $display("FAIL w_stream k=%0d valid got=%b want=1 pending=%0d", k, a_m_w.valid, exp_q.size());
        end else begin
          exp_v = exp_q.pop_front();
          if (16'(a_m_w.data) !== exp_v) begin
            bad++; $display("FAIL w_data k=%0d got=%h want=%h", k, a_m_w.data, exp_v);
          end
        end
      end
      if (k < 8) begin
        total++;
        if (a_s_w.ready !== 1'b1) begin bad++; $display("FAIL w_ready k=%0d got=%b want=1", k, a_s_w.ready); end
      end
      if (a_s_w.valid && a_s_w.ready) exp_q.push_back(16'(a_s_w.data));
      tick();
    end
    a_s_w.valid = 1'b0;
  endtask

  task automatic test_ar_full();
    logic [7:0] addrs [4];
    int sent = 0;
    int rcv  = 0;
    addrs = '{8'h10, 8'h20, 8'h30, 8'h40};
    exp_q.delete();
    for (int c = 0; c < 12; c++) begin
      a_s_ar.valid = (sent < 4);
      a_s_ar.addr  = addrs[(sent < 4) ? sent : 3];
      a_m_ar.ready = (c >= 5);
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        total++;
        if (a_s_ar.ready !== 1'b0) begin bad++; $display("FAIL ar_full_ready c=%0d got=%b want=0", c, a_s_ar.ready); end
      end
      if (c == 6) begin
        total++;
        if (a_s_ar.ready !== 1'b1) begin bad++; $display("FAIL ar_refill_ready c=%0d got=%b want=1", c, a_s_ar.ready); end
      end
      if (a_m_ar.valid && a_m_ar.ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL ar_full_out c=%0d got=%h want=none", c, a_m_ar.addr);
        end else begin
          exp_v = exp_q.pop_front();
          if (16'(a_m_ar.addr) !== exp_v) begin
            bad++; $display("FAIL ar_full_out c=%0d got=%h want=%h", c, a_m_ar.addr, exp_v);
          end
        end
        rcv++;
      end
      if (a_s_ar.valid && a_s_ar.ready) begin
        exp_q.push_back(16'(a_s_ar.addr));
        sent++;
      end
      tick();
    end
    a_s_ar.valid = 1'b0;
    total++;
    if (rcv !== 4) begin bad++; $display("FAIL ar_full_count got=%0d want=4", rcv); end
  endtask

  task automatic test_random_ar();
    int sent = 0;
    int rcv  = 0;
    bit acc;
    exp_q.delete();
    a_s_ar.valid = 1'b0;
    for (int c = 0; c < 600 && rcv < 40; c++) begin
      if (!a_s_ar.valid && sent < 40 && $urandom_range(0, 3) != 0) begin
        a_s_ar.valid = 1'b1;
        a_s_ar.addr  = 8'($urandom_range(0, 255));
        a_s_ar.id    = 1'($urandom_range(0, 1));
      end
      a_m_ar.ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (a_m_ar.valid && a_m_ar.ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL ar_rand_out got=%h want=none", {a_m_ar.id, a_m_ar.addr});
        end else begin
          exp_v = exp_q.pop_front();
          if (16'({a_m_ar.id, a_m_ar.addr}) !== exp_v) begin
            bad++; $display("FAIL ar_rand_out got=%h want=%h", {a_m_ar.id, a_m_ar.addr}, exp_v);
          end
        end
        rcv++;
      end
      acc = a_s_ar.valid && a_s_ar.ready;
      if (acc) begin
        exp_q.push_back(16'({a_s_ar.id, a_s_ar.addr}));
        sent++;
      end
      tick();
      if (acc) a_s_ar.valid = 1'b0;
    end
    a_s_ar.valid = 1'b0;
    a_m_ar.ready = 1'b1;
    total++;
    if (rcv !== 40) begin bad++; $display("FAIL ar_rand_count got=%0d want=40", rcv); end
  endtask

  task automatic test_full_pop();
    logic [7:0] addrs [3];
    int sent = 0;
    int rcv  = 0;
    addrs = '{8'hA1, 8'hA2, 8'hA3};
    exp_q.delete();
    for (int c = 0; c < 8; c++) begin
      b_s_aw.valid = (sent < 3);
      b_s_aw.addr  = addrs[(sent < 3) ? sent : 2];
      b_m_aw.ready = (c >= 2);
      @(negedge clk);
      if (c == 2) begin
        total++;
        if (b_s_aw.ready !== 1'b0 || b_m_aw.valid !== 1'b1) begin
          bad++; $display("FAIL aw_full_pop ready got=%b want=0 valid got=%b want=1", b_s_aw.ready, b_m_aw.valid);
        end
      end
      if (c == 3) begin
        total++;
        if (b_s_aw.ready !== 1'b1) begin bad++; $display("FAIL aw_next_accept got=%b want=1", b_s_aw.ready); end
      end
      if (b_m_aw.valid && b_m_aw.ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL aw_out c=%0d got=%h want=none", c, b_m_aw.addr);
        end else begin
          exp_v = exp_q.pop_front();
          if (16'(b_m_aw.addr) !== exp_v) begin
            bad++; $display("FAIL aw_out c=%0d got=%h want=%h", c, b_m_aw.addr, exp_v);
          end
        end
        rcv++;
      end
      if (b_s_aw.valid && b_s_aw.ready) begin
        exp_q.push_back(16'(b_s_aw.addr));
        sent++;
      end
      tick();
    end
    b_s_aw.valid = 1'b0;
    total++;
    if (rcv !== 3) begin bad++; $display("FAIL aw_full_count got=%0d want=3", rcv); end
  endtask

  task automatic test_passthrough();
    bit rdy;
    b_s_r.ready = 1'b0;
    {b_m_r.id, b_m_r.data, b_m_r.resp, b_m_r.last, b_m_r.user} = {1'b1, 8'hA5, 2'b00, 1'b1, 1'b0};
    b_m_r.valid = 1'b1;
    @(negedge clk);
    total++;
    if (b_s_r.valid !== 1'b1 || b_s_r.id !== 1'b1 || b_s_r.data !== 8'hA5) begin
      bad++; $display("FAIL r_pass got valid=%b id=%b data=%h want valid=1 id=1 data=a5", b_s_r.valid, b_s_r.id, b_s_r.data);
    end
    total++;
    if (b_m_r.ready !== 1'b0) begin bad++; $display("FAIL r_pass_ready_low got=%b want=0", b_m_r.ready); end
    #1;
    b_s_r.ready = 1'b1;
    #1;
    total++;
    if (b_m_r.ready !== 1'b1) begin bad++; $display("FAIL r_pass_ready_high got=%b want=1", b_m_r.ready); end
    tick();
    b_m_r.valid = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      b_s_w.data  = 8'($urandom_range(0, 255));
      b_s_w.valid = 1'b1;
      rdy = 1'($urandom_range(0, 1));
      b_m_w.ready = rdy;
      exp_q.push_back(16'(b_s_w.data));
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if (b_m_w.valid !== 1'b1 || 16'(b_m_w.data) !== exp_v || b_s_w.ready !== rdy) begin
        bad++; $display("FAIL w_pass k=%0d got valid=%b data=%h ready=%b want 1 %h %b",
                        k, b_m_w.valid, b_m_w.data, b_s_w.ready, exp_v, rdy);
      end
      tick();
    end
    b_s_w.valid = 1'b0;
    b_m_w.ready = 1'b1;
  endtask

  task automatic test_reset_flush();
    a_s_b.ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a_m_b.valid = 1'b1;
      a_m_b.id    = (k == 0) ? 1'b1 : 1'b0;
      a_m_b.resp  = (k == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      total++;
      if (a_m_b.ready !== 1'b1) begin bad++; $display("FAIL b_fill k=%0d ready got=%b want=1", k, a_m_b.ready); end
      tick();
    end
    a_m_b.valid = 1'b0;
    @(negedge clk);
    total++;
    if (a_s_b.valid !== 1'b1 || a_s_b.id !== 1'b1 || a_s_b.resp !== 2'b10) begin
      bad++; $display("FAIL b_buffered got valid=%b id=%b resp=%b want 1 1 10", a_s_b.valid, a_s_b.id, a_s_b.resp);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (a_s_b.valid !== 1'b0 || a_m_b.ready !== 1'b1 || a_s_aw.ready !== 1'b1) begin
      bad++; $display("FAIL b_flush got valid=%b b_ready=%b aw_ready=%b want 0 1 1", a_s_b.valid, a_m_b.ready, a_s_aw.ready);
    end
    a_s_b.ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (a_s_b.valid !== 1'b0) begin bad++; $display("FAIL b_stale k=%0d valid got=%b want=0", k, a_s_b.valid); end
      tick();
    end
  endtask

`ifdef NASTI_CHANNEL_BUF_CHK_EN
  task automatic test_chk();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b_m_aw.ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b_s_aw.valid = 1'b1;
      b_s_aw.addr  = 8'(8'h60 + k);
      tick();
    end
    b_s_aw.addr = 8'h55;
    @(negedge clk);
    total++;
    if (b_err !== 5'b00000 || b_s_aw.ready !== 1'b0) begin
      bad++; $display("FAIL chk_stall err=%b ready=%b want 00000 0", b_err, b_s_aw.ready);
    end
    tick();
    b_s_aw.valid = 1'b0;
    @(negedge clk);
    total++;
    if (b_err !== 5'b00000) begin bad++; $display("FAIL chk_early got=%b want=00000", b_err); end
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (b_err !== 5'b00001) begin bad++; $display("FAIL chk_err k=%0d got=%b want=00001", k, b_err); end
      tick();
    end
    b_m_aw.ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (b_err !== 5'b00000) begin bad++; $display("FAIL chk_clear got=%b want=00000", b_err); end
    tick();
  endtask
`endif

  initial begin
    init_all();
    test_reset();
    test_w_stream();
    test_ar_full();
    test_random_ar();
    test_full_pop();
    test_passthrough();
    test_reset_flush();
`ifdef NASTI_CHANNEL_BUF_CHK_EN
    test_chk();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
